// File: rtl/led_pattern_driver.sv
// Multi-channel LED pad driver for SB_IO tristate pads: binary count, PWM,
// tristate probe with synchronized readback accumulation, and off modes.
module led_pattern_driver #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CLK_HZ   = 24000000,
  parameter int unsigned TICK_HZ  = 1,
  parameter int unsigned PWM_BITS = 4,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic [CHANNELS*PWM_BITS-1:0] duty,
  input  logic [CHANNELS-1:0]          led_i,
  output logic [CHANNELS-1:0]          led_o,
  output logic [CHANNELS-1:0]          led_oe,
  output logic                         tick,
  output logic [CHANNELS-1:0]          count,
  output logic [CNT_BITS-1:0]          pad_cnt
);

  localparam int unsigned DIV    = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned POP_W  = $clog2(CHANNELS + 1);
  localparam int unsigned SUM_W  = CNT_BITS + 1;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_PWM   = 2'd1,
    MODE_PROBE = 2'd2,
    MODE_OFF   = 2'd3
  } mode_e;

  mode_e                 mode_q, mode_d;
  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [PWM_BITS-1:0]   pwm_q, pwm_d;
  logic                  phase_q, phase_d;
  logic [CHANNELS-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CHANNELS-1:0]   led_o_d, led_oe_d, count_d;
  logic                  tick_d;
  logic [CNT_BITS-1:0]   pad_cnt_d;
  logic [POP_W-1:0]      pop;
  logic [SUM_W-1:0]      pad_sum;
  logic                  wrap;

  // State register; every bit resets to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_COUNT;
      presc_q <= '0;
      pwm_q   <= '0;
      phase_q <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
      led_o   <= '0;
      led_oe  <= '0;
      tick    <= 1'b0;
      count   <= '0;
      pad_cnt <= '0;
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      phase_q <= phase_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      led_o   <= led_o_d;
      led_oe  <= led_oe_d;
      tick    <= tick_d;
      count   <= count_d;
      pad_cnt <= pad_cnt_d;
    end
  end

  // Saturating accumulation of the synchronized pad readback.
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pop = pop + POP_W'(sync2_q[i]);
    end
    pad_sum = {1'b0, pad_cnt} + SUM_W'(pop);
  end

  assign wrap = (presc_q == PRE_W'(DIV - 1));

  // Next-state and registered-output logic; en low freezes everything but tick.
  always_comb begin
    mode_d    = mode_q;
    presc_d   = presc_q;
    pwm_d     = pwm_q;
    phase_d   = phase_q;
    sync1_d   = sync1_q;
    sync2_d   = sync2_q;
    led_o_d   = led_o;
    led_oe_d  = led_oe;
    tick_d    = 1'b0;
    count_d   = count;
    pad_cnt_d = pad_cnt;

    if (en) begin
      mode_d  = mode_e'(mode);
      sync1_d = led_i;
      sync2_d = sync1_q;

      // Pads follow the registered mode, so a mode change shows two edges later.
      unique case (mode_q)
        MODE_COUNT: begin
          led_oe_d = '1;
          led_o_d  = count;
        end
        MODE_PWM: begin
          led_oe_d = '1;
          for (int unsigned i = 0; i < CHANNELS; i++) begin
            led_o_d[i] = (pwm_q < duty[i*PWM_BITS +: PWM_BITS]);
          end
        end
        MODE_PROBE: begin
          led_oe_d = phase_q ? '0 : '1;
          led_o_d  = phase_q ? '0 : count;
        end
        default: begin
          led_oe_d = '0;
          led_o_d  = '0;
        end
      endcase

      if (mode != mode_q) begin
        presc_d = '0;
        pwm_d   = '0;
        phase_d = 1'b0;
        count_d = '0;
      end else begin
        pwm_d = pwm_q + PWM_BITS'(1);
        if (wrap) begin
          presc_d = '0;
          tick_d  = 1'b1;
          count_d = count + CHANNELS'(1);
          phase_d = ~phase_q;
          if (mode_q == MODE_PROBE && phase_q) begin
            pad_cnt_d = pad_sum[CNT_BITS] ? '1 : pad_sum[CNT_BITS-1:0];
          end
        end else begin
          presc_d = presc_q + PRE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Randomized scoreboard bench for led_pattern_driver; the reference model
// derives all outputs from the count of enabled cycles since the last clear.
module tb_led_pattern_driver;

  localparam int unsigned CH   = 4;
  localparam int unsigned PB   = 4;
  localparam int unsigned CB   = 4;
  localparam int unsigned DIV  = 8;
  localparam int unsigned PMAX = (1 << CB) - 1;

  typedef struct packed {
    logic [CH-1:0] o;
    logic [CH-1:0] oe;
    logic          t;
    logic [CH-1:0] c;
    logic [CB-1:0] p;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [CH*PB-1:0] duty = '0;
  logic [CH-1:0]    led_i = '0;
  logic [CH-1:0]    led_o, led_oe, count;
  logic             tick;
  logic [CB-1:0]    pad_cnt;

  int checks = 0;
  int failures = 0;
  exp_t q[$];

  // Reference model state
  int            run;
  logic [1:0]    mq;
  logic [CH-1:0] s1, s2;
  int            pc;
  logic [CH-1:0] eo, eoe;
  logic          et;

  led_pattern_driver #(
    .CHANNELS(CH), .CLK_HZ(DIV), .TICK_HZ(1), .PWM_BITS(PB), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .duty(duty), .led_i(led_i),
    .led_o(led_o), .led_oe(led_oe), .tick(tick), .count(count), .pad_cnt(pad_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Behavioural step for one clock edge with the given inputs.
  task automatic model_step(input logic r, input logic e, input logic [1:0] md,
                            input logic [CH*PB-1:0] dt, input logic [CH-1:0] li);
    int k, ph, pp;
    exp_t x;
    if (r) begin
      run = 0; mq = 2'd0; s1 = '0; s2 = '0; pc = 0; eo = '0; eoe = '0; et = 1'b0;
    end else if (e) begin
      k  = run / DIV;
      ph = k % 2;
      pp = run % (1 << PB);
      case (mq)
        2'd0: begin eoe = '1; eo = CH'(k % (1 << CH)); end
        2'd1: begin
          eoe = '1;
          for (int i = 0; i < CH; i++) eo[i] = (pp < int'(dt[i*PB +: PB]));
        end
        2'd2: begin
          eoe = (ph == 1) ? '0 : '1;
          eo  = (ph == 1) ? '0 : CH'(k % (1 << CH));
        end
        default: begin eoe = '0; eo = '0; end
      endcase
      if (md != mq) run = 0;
      else begin
        if ((run % DIV) == DIV - 1 && ph == 1 && mq == 2'd2) begin
          pc = pc + $countones(s2);
          if (pc > PMAX) pc = PMAX;
        end
        run++;
      end
      s2 = s1; s1 = li; mq = md;
      et = (run > 0) && (run % DIV == 0);
    end else begin
      et = 1'b0;
    end
    x.o = eo; x.oe = eoe; x.t = et;
    x.c = CH'((run / DIV) % (1 << CH));
    x.p = CB'(pc);
    q.push_back(x);
  endtask

  task automatic cycle(input logic r, input logic e, input logic [1:0] md,
                       input logic [CH*PB-1:0] dt, input logic [CH-1:0] li);
    @(negedge clk);
    rst = r; en = e; mode = md; duty = dt; led_i = li;
    model_step(r, e, md, dt, li);
  endtask

  // Monitor: every edge the DUT presents a full output word.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("led_o",   int'(led_o),   int'(x.o));
        check("led_oe",  int'(led_oe),  int'(x.oe));
        check("tick",    int'(tick),    int'(x.t));
        check("count",   int'(count),   int'(x.c));
        check("pad_cnt", int'(pad_cnt), int'(x.p));
      end
    end
  end

  initial begin
    logic [CH*PB-1:0] dt;
    logic [1:0]       md;
    int               hi[CH];

    #1;
    check("reset_led_oe", int'(led_oe), 0);
    check("reset_count", int'(count), 0);
    repeat (3) cycle(1'b1, 1'b0, 2'd0, '0, '0);

    // Binary count through a full wrap, with a 20-cycle freeze mid-run.
    repeat (60) cycle(1'b0, 1'b1, 2'd0, '0, '0);
    repeat (20) cycle(1'b0, 1'b0, 2'd0, '0, '0);
    repeat (100) cycle(1'b0, 1'b1, 2'd0, '0, '0);

    // PWM with fixed duties, plus a duty-cycle tally over one phase period.
    dt = {4'd0, 4'd4, 4'd8, 4'd15};
    repeat (4) cycle(1'b0, 1'b1, 2'd1, dt, '0);
    for (int i = 0; i < CH; i++) hi[i] = 0;
    for (int n = 0; n < 16; n++) begin
      cycle(1'b0, 1'b1, 2'd1, dt, '0);
      for (int i = 0; i < CH; i++) hi[i] += int'(led_o[i]);
    end
    check("pwm_hi_ch0", hi[0], 15);
    check("pwm_hi_ch1", hi[1], 8);
    check("pwm_hi_ch2", hi[2], 4);
    check("pwm_hi_ch3", hi[3], 0);
    repeat (30) cycle(1'b0, 1'b1, 2'd1, 16'h3c9a, '0);

    // Probe with constant readback until the accumulator saturates.
    repeat (100) cycle(1'b0, 1'b1, 2'd2, '0, 4'b1011);
    check("pad_cnt_saturated", int'(pad_cnt), int'(PMAX));

    // OFF then PROBE, with an asynchronous reset between edges.
    repeat (12) cycle(1'b0, 1'b1, 2'd3, '0, 4'hF);
    repeat (13) cycle(1'b0, 1'b1, 2'd2, '0, 4'hF);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led_oe", int'(led_oe), 0);
    check("async_rst_led_o", int'(led_o), 0);
    check("async_rst_pad_cnt", int'(pad_cnt), 0);
    check("async_rst_count", int'(count), 0);
    model_step(1'b1, 1'b0, 2'd2, '0, 4'hF);
    repeat (2) cycle(1'b1, 1'b0, 2'd2, '0, 4'hF);
    repeat (30) cycle(1'b0, 1'b1, 2'd2, '0, 4'h6);

    // Randomized mix of modes, enables, duties, readback and rare resets.
    md = 2'd0;
    dt = 16'h0000;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 39) == 0) md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) dt = 16'($urandom);
      cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) != 0), md, dt,
            CH'($urandom));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
